// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: state encoding, phase constants and IR field-split helpers
// shared by the fetch sequencer and its PC counter.
package fetch_seq_pkg;

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_LOADED = 1'b1
    } state_e;

    localparam logic PHASE_FETCH = 1'b0;
    localparam logic PHASE_EXEC  = 1'b1;

    localparam int DEF_PC_W    = 12;
    localparam int DEF_INSTR_W = 8;

    // Opcode occupies the upper half of the ROM word, operand the lower half.
    function automatic int field_w(input int instr_w);
        return instr_w / 2;
    endfunction

    localparam int OPC_W = field_w(DEF_INSTR_W);
    localparam int OPR_W = field_w(DEF_INSTR_W);

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter register with synchronous active-low reset,
// increment enable, and a load that overrides the increment.
module pc_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q, pc_d;

    // Wraps modulo 2^W naturally through the fixed-width add.
    always_comb pc_d = load_i ? load_val_i : inc_i ? pc_q + W'(1) : pc_q;

    always_ff @(posedge clk)
        if (!reset) pc_q <= '0;
        else        pc_q <= pc_d;

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: turns the fetch/execute phase into ROM fetches, a PC and an IR.
// Optional bubble counter enabled by defining FETCH_SEQ_BUBBLE_CNT_EN.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   phase,
    input  logic                   enable_pc,
    input  logic                   load_pc,
    input  logic [PC_W-1:0]        pc_load_val,
    input  logic [INSTR_W-1:0]     rom_data,
    input  logic                   rom_valid,
`ifdef FETCH_SEQ_BUBBLE_CNT_EN
    input  logic                   bubble_clr,
    output logic [15:0]            bubble_cnt,
`endif
    output logic                   rom_req,
    output logic [PC_W-1:0]        pc_out,
    output logic [INSTR_W/2-1:0]   instr,
    output logic [INSTR_W/2-1:0]   oprnd,
    output logic                   exec_valid,
    output logic                   bubble
);

    localparam int FW = field_w(INSTR_W);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 fetch_ok, exec_go;

    assign fetch_ok = state_q == S_FETCH && phase == PHASE_FETCH && rom_valid;
    assign exec_go  = state_q == S_LOADED && phase == PHASE_EXEC;

    always_ff @(posedge clk)
        if (!reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end

    // A desynced fetch phase in S_LOADED falls through and holds everything.
    always_comb begin
        state_d = fetch_ok ? S_LOADED : exec_go ? S_FETCH : state_q;
        ir_d    = fetch_ok ? rom_data : ir_q;
    end

    always_comb begin
        rom_req    = state_q == S_FETCH && phase == PHASE_FETCH;
        exec_valid = exec_go;
        bubble     = state_q == S_FETCH && phase == PHASE_EXEC;
        instr      = ir_q[INSTR_W-1:FW];
        oprnd      = ir_q[FW-1:0];
    end

    pc_counter #(.W(PC_W)) u_pc (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (fetch_ok && enable_pc),
        .load_i     (exec_go && load_pc),
        .load_val_i (pc_load_val),
        .pc_o       (pc_out)
    );

`ifdef FETCH_SEQ_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb
        bubble_cnt_d = bubble_clr ? '0 :
                       (bubble && bubble_cnt_q != '1) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;

    always_ff @(posedge clk)
        if (!reset) bubble_cnt_q <= '0;
        else        bubble_cnt_q <= bubble_cnt_d;

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed test-plan sequences plus randomized phases,
// checked every cycle against a behavioural fetch/execute model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, phase, enable_pc, load_pc, rom_valid, bubble_clr;
    logic [11:0] pc_load_val;
    logic [7:0]  rom_data;
    logic        rom_req, exec_valid, bubble;
    logic [11:0] pc_out;
    logic [3:0]  instr, oprnd;
`ifdef FETCH_SEQ_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    int   m_pc;
    int   m_ir;
    bit   m_loaded;
    int   m_cnt;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .phase       (phase),
        .enable_pc   (enable_pc),
        .load_pc     (load_pc),
        .pc_load_val (pc_load_val),
        .rom_data    (rom_data),
        .rom_valid   (rom_valid),
`ifdef FETCH_SEQ_BUBBLE_CNT_EN
        .bubble_clr  (bubble_clr),
        .bubble_cnt  (bubble_cnt),
`endif
        .rom_req     (rom_req),
        .pc_out      (pc_out),
        .instr       (instr),
        .oprnd       (oprnd),
        .exec_valid  (exec_valid),
        .bubble      (bubble)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, compare outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic r, input logic ph, input logic en, input logic ld,
                        input logic [11:0] val, input logic [7:0] data,
                        input logic vld, input logic clr);
        bit fetch_go, exec_go, bub;
        reset = r; phase = ph; enable_pc = en; load_pc = ld;
        pc_load_val = val; rom_data = data; rom_valid = vld; bubble_clr = clr;
        fetch_go = !m_loaded && ph == 1'b0 && vld;
        exec_go  = m_loaded && ph == 1'b1;
        bub      = !m_loaded && ph == 1'b1;
        @(negedge clk);
        if (chk_en) begin
            chk("rom_req", rom_req, 16'(!m_loaded && ph == 1'b0));
            chk("exec_valid", exec_valid, 16'(exec_go));
            chk("bubble", bubble, 16'(bub));
            chk("pc_out", pc_out, 16'(m_pc));
            chk("instr", instr, 16'(m_ir / 16));
            chk("oprnd", oprnd, 16'(m_ir % 16));
`ifdef FETCH_SEQ_BUBBLE_CNT_EN
            chk("bubble_cnt", bubble_cnt, 16'(m_cnt));
`endif
        end
        @(posedge clk);
        if (!r) begin
            m_pc = 0; m_ir = 0; m_loaded = 0; m_cnt = 0;
        end else begin
            if (fetch_go) begin
                m_ir = int'(data);
                if (en) m_pc = (m_pc + 1) % 4096;
                m_loaded = 1;
            end else if (exec_go) begin
                if (ld) m_pc = int'(val);
                m_loaded = 0;
            end
            if (clr) m_cnt = 0;
            else if (bub && m_cnt < 65535) m_cnt++;
        end
        chk_en = 1;
        #1;
    endtask

    task automatic fetch(input logic [7:0] data, input logic vld, input logic en);
        step(1, 0, en, 0, 12'h000, data, vld, 0);
    endtask

    task automatic exec(input logic ld, input logic [11:0] val);
        step(1, 1, 1, ld, val, 8'h00, 1, 0);
    endtask

    initial begin
        logic ph;
        reset = 0; phase = 0; enable_pc = 0; load_pc = 0; pc_load_val = '0;
        rom_data = '0; rom_valid = 0; bubble_clr = 0;
        m_pc = 0; m_ir = 0; m_loaded = 0; m_cnt = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0);
        step(0, 1, 0, 0, 12'h000, 8'h00, 0, 0);
        chk("rst_pc", pc_out, 16'h0);
        chk("rst_ir", {instr, oprnd}, 16'h0);

        fetch(8'hA5, 1, 1);
        chk("tp_pc1", pc_out, 16'h001);
        chk("tp_ir", {instr, oprnd}, 16'h00A5);
        exec(0, 12'h000);

        fetch(8'h11, 1, 0);
        exec(1, 12'h07F);
        fetch(8'h22, 1, 0);
        chk("tp_pc7f", pc_out, 16'h07F);
        exec(1, 12'h200);
        chk("tp_jump", pc_out, 16'h200);

        fetch(8'h33, 0, 1);
        exec(1, 12'h555);
        chk("tp_bubble_pc", pc_out, 16'h200);
        fetch(8'h44, 1, 1);
        chk("tp_refetch", pc_out, 16'h201);
        exec(1, 12'hFFF);
        fetch(8'h5C, 1, 1);
        chk("tp_wrap", pc_out, 16'h000);
        exec(1, 12'hFFF);
        fetch(8'h6D, 1, 0);
        chk("tp_hold", pc_out, 16'hFFF);
        chk("tp_hold_ir", {instr, oprnd}, 16'h006D);

        fetch(8'h77, 1, 1);
        fetch(8'h88, 1, 1);
        fetch(8'h99, 1, 1);
        chk("tp_desync_ir", {instr, oprnd}, 16'h006D);
        exec(0, 12'h000);

        fetch(8'hBE, 1, 1);
        step(0, 1, 1, 1, 12'h123, 8'h00, 1, 0);
        chk("tp_rst_pc", pc_out, 16'h000);
        chk("tp_rst_ir", {instr, oprnd}, 16'h0000);

`ifdef FETCH_SEQ_BUBBLE_CNT_EN
        exec(0, 12'h000);
        exec(0, 12'h000);
        exec(0, 12'h000);
        chk("tp_bcnt3", bubble_cnt, 16'd3);
        step(1, 1, 1, 0, 12'h000, 8'h00, 1, 1);
        chk("tp_bclr", bubble_cnt, 16'd0);
`endif

        ph = 0;
        for (int i = 0; i < 3000; i++) begin
            ph = ($urandom_range(0, 9) < 8) ? ~ph : 1'($urandom);
            step($urandom_range(0, 49) != 0, ph, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 3,
                 ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom),
                 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Consumer side of the processor's phase signal: turns the toggling fetch/execute phase (0 = fetch, 1 = execute) into program-ROM fetch requests, a program counter, and an instruction register.
- Each execute phase presents one decoded instruction/operand pair to the decoder.
- Sits between the phase toggle, the program ROM and the instruction decoder; owns the PC and the jump load path.

Parameters:
- PC_W, 12, program counter / ROM address width.
- INSTR_W, 8, ROM word width; upper half is the opcode, lower half is the operand (must be even).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- phase  in  1  current phase from the phase toggle; 0 = fetch, 1 = execute.
- enable_pc  in  1  1 = PC increments after a successful fetch; 0 = PC holds.
- load_pc  in  1  jump request; honoured only in a cycle where exec_valid=1.
- pc_load_val  in  PC_W  jump target.
- rom_data  in  INSTR_W  ROM read data for address pc_out.
- rom_valid  in  1  rom_data valid this cycle; ignored while rom_req=0.
- rom_req  out  1  fetch request; address is pc_out.
- pc_out  out  PC_W  current program counter.
- instr  out  INSTR_W/2  opcode field, IR[INSTR_W-1:INSTR_W/2].
- oprnd  out  INSTR_W/2  operand field, IR[INSTR_W/2-1:0].
- exec_valid  out  1  instr/oprnd valid for execution this cycle.
- bubble  out  1  execute phase with no loaded instruction.

Behaviour:
- All state updates occur on the rising clk edge. reset=0 has priority over everything: PC=0, IR=0, state=S_FETCH, all outputs 0 on the following cycle. Reset mid-fetch or mid-execute discards the IR contents and any pending jump.
- States are S_FETCH (IR empty) and S_LOADED (IR holds an unexecuted instruction).
- Combinational outputs:
  - rom_req = (state==S_FETCH) && phase==0.
  - exec_valid = (state==S_LOADED) && phase==1.
  - bubble = (state==S_FETCH) && phase==1.
  - instr and oprnd always reflect IR.
- S_FETCH, phase=0, rom_valid=1:
  - IR <= rom_data.
  - PC <= PC+1 if enable_pc, else PC holds.
  - Next state S_LOADED.
- S_FETCH, phase=0, rom_valid=0: no change; the request stays asserted.
- S_FETCH, phase=1: bubble=1, no PC/IR change, stay in S_FETCH. Refetch of the same PC happens on the next fetch phase.
- S_LOADED, phase=1:
  - exec_valid=1 for exactly that cycle.
  - If load_pc=1, PC <= pc_load_val; the jump overrides any increment.
  - Next state S_FETCH.
- S_LOADED, phase=0 (phase desync): hold IR and PC, rom_req=0, stay in S_LOADED. The instruction is never overwritten before it executes.
- load_pc while exec_valid=0 is ignored.
- PC arithmetic is modulo 2^PC_W: 2^PC_W-1 increments to 0.
- Latency: with a combinational ROM (rom_valid=1 in the fetch cycle), an instruction fetched in cycle n executes in cycle n+1. One instruction completes per fetch/execute pair.

Optional Feature:
- Macro: FETCH_SEQ_BUBBLE_CNT_EN.
- When defined:
  - Adds output bubble_cnt [15:0], which increments by 1 on every cycle with bubble=1.
  - Saturates at 16'hFFFF; cleared by reset.
  - Adds input bubble_clr; bubble_clr=1 clears the counter next cycle and takes priority over the increment.
- When undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Package fetch_seq_pkg holds:
  - the state encoding (S_FETCH=1'b0, S_LOADED=1'b1);
  - PHASE_FETCH=1'b0 and PHASE_EXEC=1'b1;
  - opcode/operand field-split constants derived from INSTR_W.
- One natural sub-module, pc_counter: a PC_W-bit register with synchronous active-low reset, increment enable, and load that takes priority over increment.

Test Plan:
- Reset low for 2 cycles, then high; phase toggles 0,1,... with rom_data=8'hA5, rom_valid=1, enable_pc=1 → after the first fetch pc_out=1, next cycle exec_valid=1, instr=4'hA, oprnd=4'h5.
- pc_out=12'h07F in execute with load_pc=1, pc_load_val=12'h200 → pc_out=12'h200, and the next rom_req addresses 12'h200.
- rom_valid=0 during a fetch phase → the next execute cycle shows bubble=1, exec_valid=0, and the PC is unchanged. The following fetch reissues rom_req at the same pc_out.
- Force pc_out=12'hFFF (via load), fetch with enable_pc=1 → pc_out=12'h000. Repeat with enable_pc=0 → pc_out holds while IR still loads.
- Phase held at 0 for 3 cycles in S_LOADED → rom_req=0 and IR unchanged. The first phase=1 then gives exec_valid=1 with the original instruction.
- Assert reset low in an execute cycle with load_pc=1 → next cycle pc_out=0, exec_valid=0, IR=0, and no jump is taken. With FETCH_SEQ_BUBBLE_CNT_EN defined, 3 bubbles give bubble_cnt=3, and bubble_clr=1 returns it to 0.
